// File: rtl/int_div_32.sv
// int_div_32: sequential 32-bit non-restoring divider, one add/subtract step per clock.
// Start/busy/done handshake. Define INT_DIV_SIGNED_EN for two's-complement operands;
// without it the operands are unsigned and no sign logic is built.
module int_div_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_p_shift;
    logic [WIDTH:0]   w_p_step;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q_out;
    logic [WIDTH-1:0] w_r_out;

`ifdef INT_DIV_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
`endif

    // A start is not accepted in the cycle the done pulse is showing.
    assign w_accept = (r_state == StIdle) && start && !r_done;
    assign w_zero   = (divisor == '0);

`ifdef INT_DIV_SIGNED_EN
    assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    // Sign of P before the shift equals the sign of the shifted value, so it picks add/sub.
    assign w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_p_step  = r_p[WIDTH] ? (w_p_shift + {1'b0, r_d}) : (w_p_shift - {1'b0, r_d});
    assign w_r_mag   = r_p[WIDTH-1:0] + (r_p[WIDTH] ? r_d : '0);

`ifdef INT_DIV_SIGNED_EN
    assign w_q_out = r_neg_q ? (~r_q + WIDTH'(1)) : r_q;
    assign w_r_out = r_neg_r ? (~w_r_mag + WIDTH'(1)) : w_r_mag;
`else
    assign w_q_out = r_q;
    assign w_r_out = w_r_mag;
`endif

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = w_zero ? StDone : StRun;
            StRun:   if (r_cnt == 5'd31) w_state_next = StFix;
            StFix:   w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, result registers and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef INT_DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == StDone);
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_p    <= '0;
                        r_q    <= w_dvd_mag;
                        r_d    <= w_dvs_mag;
`ifdef INT_DIV_SIGNED_EN
                        r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r <= dividend[WIDTH-1];
`endif
                        if (w_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_div_zero  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    r_p   <= w_p_step;
                    r_q   <= {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
                    r_cnt <= r_cnt + 5'd1;
                end
                StFix: begin
                    r_quotient  <= w_q_out;
                    r_remainder <= w_r_out;
                end
                StDone: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule
